argmax_decider: RTL and testbench
=================================

ARGMAX_DECIDER -- requirements
Module: argmax_decider

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10, number of scores per frame.
REQ-002 SHALL have parameter DATA_W, default 12, signed score width.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port valid_in, input, 1, one score present on data_in this cycle.
REQ-006 SHALL have port data_in, input, DATA_W, signed two's-complement class score from the fully connected stage.
REQ-007 SHALL have port decision_valid, output, 1, decision register holds an untaken result.
REQ-008 SHALL have port decision_ready, input, 1, consumer accepts the decision.
REQ-009 SHALL have port digit, output, 4, index of winning class.
REQ-010 SHALL have port max_score, output, DATA_W, signed winning score.
REQ-011 SHALL have port margin, output, DATA_W+1, unsigned value: winner minus runner-up.
REQ-012 SHALL have port overrun, output, 1, sticky flag: untaken decision overwritten.
REQ-013 SHALL have port frame_cnt, output, 16, count of completed frames.

Function
REQ-014 SHALL sample data_in only in cycles with valid_in=1; the class index is the position within the frame (0..NUM_CLASSES-1), tracked by counter cnt.
REQ-015 SHALL, on sample with cnt=0, load best=data_in, best_idx=0, second=most-negative DATA_W value.
REQ-016 SHALL, on sample with cnt>0: if data_in > best then second=best, best=data_in, best_idx=cnt; else if data_in > second then second=data_in.
REQ-017 SHALL use strict signed compare, so on a tie the lowest index wins and second takes the tied value (margin 0).
REQ-018 SHALL, on the sample with cnt=NUM_CLASSES-1, wrap cnt to 0 and mark the frame complete.
REQ-019 SHALL, in the cycle after frame completion, have digit, max_score, margin=best-second (sign-extended subtraction, result non-negative) and decision_valid=1 registered; latency from last sample to decision_valid is 1 cycle.
REQ-020 SHALL keep the accumulator and the decision register separate, so a new frame accumulates while a decision is pending.
REQ-021 SHALL treat the decision as transferred in any cycle with decision_valid=1 and decision_ready=1; decision_valid then clears next cycle unless a new frame completes in the same cycle.
REQ-022 SHALL hold digit/max_score/margin stable while decision_valid=1 and decision_ready=0.
REQ-023 SHALL, when a frame completes while decision_valid=1 and decision_ready=0, overwrite the decision, keep decision_valid=1, and set overrun=1.
REQ-024 SHALL, when a frame completes in the same cycle as a transfer, load the new decision with decision_valid=1 and no overrun.
REQ-025 SHALL increment frame_cnt once per completed frame, wrapping from 0xFFFF to 0.
REQ-026 SHALL leave decision_ready ignored while decision_valid=0.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, clear cnt, best, second, best_idx, digit, max_score, margin, decision_valid, overrun and frame_cnt to 0.
REQ-028 SHALL discard any partial frame on reset mid-frame; the first sample after reset is class 0.
REQ-029 SHALL hold overrun at 1 until reset.

Structure
REQ-030 SHALL place NUM_CLASSES, DATA_W, index width (4) and the most-negative score constant in a shared cnn package.
REQ-031 SHALL implement the compare/update as one sub-module, argmax_update (combinational: best, second, idx, sample in; next values out).
REQ-032 SHALL contain no multipliers; one subtractor, two signed comparators.

Verification
REQ-033 SHALL cover: scores 5,-3,100,7,0,0,0,0,0,99 back-to-back, ready=1 -> digit=2, max_score=100, margin=1, decision_valid for 1 cycle, 1 cycle after last sample.
REQ-034 SHALL cover: all ten scores = -2048 -> digit=0, max_score=-2048, margin=0.
REQ-035 SHALL cover: scores 50 at index 3 and 50 at index 7, rest 0 -> digit=3, margin=0.
REQ-036 SHALL cover: ready=0 through two frames (winner 4, then winner 8) -> digit=8, overrun=1, decision_valid stays 1 until ready; frame_cnt=2.
REQ-037 SHALL cover: reset after 6 samples, then a full frame with winner 9 -> digit=9, frame_cnt=1.
REQ-038 SHALL cover: gapped valid_in (1 sample every 3 cycles), winner 6, with a completion coinciding with a transfer -> no overrun, new decision held.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants for the classifier back end: frame geometry and score format.
package cnn_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int DATA_W      = 12;
    localparam int IDX_W       = 4;

    localparam logic signed [DATA_W-1:0] SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/argmax_update.sv
// One step of the running top-two search over a frame of class scores.
module argmax_update #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int IDX_W  = cnn_pkg::IDX_W
) (
    input  logic [DATA_W-1:0] best,
    input  logic [DATA_W-1:0] second,
    input  logic [IDX_W-1:0]  best_idx,
    input  logic [DATA_W-1:0] sample,
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] best_nxt,
    output logic [DATA_W-1:0] second_nxt,
    output logic [IDX_W-1:0]  idx_nxt
);
    import cnn_pkg::*;

    localparam logic [DATA_W-1:0] FLOOR = {1'b1, {(DATA_W-1){1'b0}}};

    logic gt_best;
    logic gt_second;

    // Strict compares: a tie never displaces the earlier (lower) index.
    assign gt_best   = $signed(sample) > $signed(best);
    assign gt_second = $signed(sample) > $signed(second);

    always_comb begin
        best_nxt   = best;
        second_nxt = second;
        idx_nxt    = best_idx;
        if (idx == '0) begin
            best_nxt   = sample;
            second_nxt = FLOOR;
            idx_nxt    = '0;
        end else if (gt_best) begin
            best_nxt   = sample;
            second_nxt = best;
            idx_nxt    = idx;
        end else if (gt_second) begin
            second_nxt = sample;
        end
    end

endmodule

// File: rtl/argmax_decider.sv
// Frame-wise argmax over streamed class scores with a one-deep decision register and handshake.
module argmax_decider #(
    parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES,
    parameter int DATA_W      = cnn_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              decision_valid,
    input  logic              decision_ready,
    output logic [3:0]        digit,
    output logic [DATA_W-1:0] max_score,
    output logic [DATA_W:0]   margin,
    output logic              overrun,
    output logic [15:0]       frame_cnt
);
    import cnn_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    logic [IDX_W-1:0]  cnt;
    logic [DATA_W-1:0] best;
    logic [DATA_W-1:0] second;
    logic [IDX_W-1:0]  best_idx;

    logic [DATA_W-1:0] best_nxt;
    logic [DATA_W-1:0] second_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic [DATA_W:0]   margin_nxt;
    logic              frame_done;
    logic              xfer;

    argmax_update #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_update (
        .best       (best),
        .second     (second),
        .best_idx   (best_idx),
        .sample     (data_in),
        .idx        (cnt),
        .best_nxt   (best_nxt),
        .second_nxt (second_nxt),
        .idx_nxt    (idx_nxt)
    );

    assign frame_done = valid_in && (cnt == LAST_IDX);
    assign xfer       = decision_valid && decision_ready;

    // best >= second always holds, so the widened difference is non-negative.
    assign margin_nxt = {best_nxt[DATA_W-1], best_nxt} - {second_nxt[DATA_W-1], second_nxt};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            best     <= '0;
            second   <= '0;
            best_idx <= '0;
        end else if (valid_in) begin
            best     <= best_nxt;
            second   <= second_nxt;
            best_idx <= idx_nxt;
            cnt      <= frame_done ? '0 : cnt + 1'b1;
        end
    end

    // Decision register is independent of the accumulator so the next frame can fill behind it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            decision_valid <= 1'b0;
            digit          <= '0;
            max_score      <= '0;
            margin         <= '0;
            overrun        <= 1'b0;
            frame_cnt      <= '0;
        end else begin
            if (frame_done) begin
                decision_valid <= 1'b1;
                digit          <= idx_nxt;
                max_score      <= best_nxt;
                margin         <= margin_nxt;
                frame_cnt      <= frame_cnt + 16'd1;
                if (decision_valid && !decision_ready) begin
                    overrun <= 1'b1;
                end
            end else if (xfer) begin
                decision_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_argmax_decider.sv
// Bench for argmax_decider: frame-level reference model checked every cycle, plus directed literal checks.
module tb_argmax_decider;

    localparam int NC = 10;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          decision_ready = 1'b0;
    logic          decision_valid;
    logic [3:0]    digit;
    logic [DW-1:0] max_score;
    logic [DW:0]   margin;
    logic          overrun;
    logic [15:0]   frame_cnt;

    argmax_decider #(.NUM_CLASSES(NC), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .decision_valid (decision_valid),
        .decision_ready (decision_ready),
        .digit          (digit),
        .max_score      (max_score),
        .margin         (margin),
        .overrun        (overrun),
        .frame_cnt      (frame_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    // Reference state: the scores of the frame in progress and the expected decision.
    int          smp[NC];
    int          n = 0;
    bit          e_valid = 1'b0;
    bit          e_over = 1'b0;
    logic [3:0]  e_digit = '0;
    logic [11:0] e_max = '0;
    logic [12:0] e_margin = '0;
    logic [15:0] e_fcnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit done;
        int bi;
        int sv;
        if (!rst_n) begin
            n = 0;
            e_valid = 0; e_over = 0; e_digit = '0; e_max = '0; e_margin = '0; e_fcnt = '0;
        end else begin
            done = 0;
            if (valid_in) begin
                smp[n] = int'($signed(data_in));
                n++;
                if (n == NC) begin
                    done = 1;
                    n = 0;
                end
            end
            if (done) begin
                bi = 0;
                for (int i = 1; i < NC; i++) if (smp[i] > smp[bi]) bi = i;
                sv = -100000;
                for (int i = 0; i < NC; i++) if (i != bi && smp[i] > sv) sv = smp[i];
                if (e_valid && !decision_ready) e_over = 1;
                e_valid  = 1;
                e_digit  = 4'(bi);
                e_max    = 12'(smp[bi]);
                e_margin = 13'(smp[bi] - sv);
                e_fcnt   = e_fcnt + 16'd1;
            end else if (e_valid && decision_ready) begin
                e_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("decision_valid", 32'(decision_valid), 32'(e_valid));
            chk("overrun", 32'(overrun), 32'(e_over));
            chk("frame_cnt", 32'(frame_cnt), 32'(e_fcnt));
            if (e_valid) begin
                chk("digit", 32'(digit), 32'(e_digit));
                chk("max_score", 32'(max_score), 32'(e_max));
                chk("margin", 32'(margin), 32'(e_margin));
            end
        end
    end

    task automatic send_frame(input int s[NC], input int gap, input bit rdy_last);
        for (int i = 0; i < NC; i++) begin
            repeat (gap) begin
                @(negedge clk);
                valid_in = 1'b0;
            end
            @(negedge clk);
            valid_in = 1'b1;
            data_in  = s[i][DW-1:0];
            if (rdy_last && i == NC - 1) decision_ready = 1'b1;
        end
        @(negedge clk);
        valid_in = 1'b0;
        if (rdy_last) decision_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        int f[NC];

        repeat (3) @(negedge clk);
        checking = 1'b1;
        chk("reset_valid", 32'(decision_valid), 32'd0);
        chk("reset_digit", 32'(digit), 32'd0);
        chk("reset_max", 32'(max_score), 32'd0);
        chk("reset_margin", 32'(margin), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_fcnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;

        // Back-to-back frame, consumer always ready: one-cycle decision pulse.
        decision_ready = 1'b1;
        f = '{5, -3, 100, 7, 0, 0, 0, 0, 0, 99};
        send_frame(f, 0, 1'b0);
        chk("t33_valid", 32'(decision_valid), 32'd1);
        chk("t33_digit", 32'(digit), 32'd2);
        chk("t33_max", 32'(max_score), 32'd100);
        chk("t33_margin", 32'(margin), 32'd1);
        @(negedge clk);
        chk("t33_pulse", 32'(decision_valid), 32'd0);

        f = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
        send_frame(f, 0, 1'b0);
        chk("t34_digit", 32'(digit), 32'd0);
        chk("t34_max", 32'(max_score), 32'h800);
        chk("t34_margin", 32'(margin), 32'd0);

        f = '{0, 0, 0, 50, 0, 0, 0, 50, 0, 0};
        send_frame(f, 0, 1'b0);
        chk("t35_digit", 32'(digit), 32'd3);
        chk("t35_margin", 32'(margin), 32'd0);

        // Two frames while the consumer stalls.
        do_reset();
        decision_ready = 1'b0;
        f = '{1, 2, 3, 4, 40, 5, 6, 7, 8, 9};
        send_frame(f, 0, 1'b0);
        f = '{1, 2, 3, 4, 5, 6, 7, 8, 70, 9};
        send_frame(f, 0, 1'b0);
        chk("t36_digit", 32'(digit), 32'd8);
        chk("t36_overrun", 32'(overrun), 32'd1);
        chk("t36_valid", 32'(decision_valid), 32'd1);
        chk("t36_fcnt", 32'(frame_cnt), 32'd2);
        repeat (3) @(negedge clk);
        chk("t36_hold", 32'(decision_valid), 32'd1);
        decision_ready = 1'b1;
        @(negedge clk);
        decision_ready = 1'b0;
        chk("t36_taken", 32'(decision_valid), 32'd0);
        chk("t36_sticky", 32'(overrun), 32'd1);

        // Reset mid-frame discards the partial frame.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            data_in = 12'd77;
        end
        @(negedge clk);
        valid_in = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        f = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 500};
        send_frame(f, 0, 1'b0);
        chk("t37_digit", 32'(digit), 32'd9);
        chk("t37_fcnt", 32'(frame_cnt), 32'd1);
        chk("t37_overrun", 32'(overrun), 32'd0);

        // Gapped input; second completion coincides with a transfer.
        do_reset();
        decision_ready = 1'b0;
        f = '{0, 10, 20, 30, 40, 50, 300, 70, 80, 90};
        send_frame(f, 2, 1'b0);
        chk("t38_first_digit", 32'(digit), 32'd6);
        chk("t38_first_margin", 32'(margin), 32'd210);
        f = '{0, 10, 20, 30, 40, 50, 200, 70, 80, 90};
        send_frame(f, 2, 1'b1);
        chk("t38_valid", 32'(decision_valid), 32'd1);
        chk("t38_overrun", 32'(overrun), 32'd0);
        chk("t38_max", 32'(max_score), 32'd200);
        chk("t38_fcnt", 32'(frame_cnt), 32'd2);
        repeat (3) @(negedge clk);
        chk("t38_hold", 32'(decision_valid), 32'd1);
        chk("t38_hold_max", 32'(max_score), 32'd200);

        // Randomized traffic with extremes, ties, stalls and occasional resets.
        do_reset();
        repeat (4000) begin
            @(negedge clk);
            valid_in = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       data_in = 12'h800;
                1:       data_in = 12'h7FF;
                2, 3:    data_in = 12'($urandom_range(0, 3));
                default: data_in = 12'($urandom);
            endcase
            decision_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 599) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        checking = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
